mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Sequencing controller that sits directly upstream of the 4-to-1 mux (`mux_4to1`) and drives its `s0`/`s1` select lines. It walks the enabled input channels in ascending, wrap-around order, holds each select for a programmable settle time, and samples the mux output `y` fed back on `y_in`. Each sample is emitted as a one-cycle valid strobe with its channel number. After every complete pass over the enabled channels, it also presents a 4-bit frame snapshot. Runs in single-pass or continuous mode.

## Interface
- `DWELL`, default 4: settle cycles per channel before sampling; legal range 1..255.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level; begins a scan when sampled high in IDLE.
- `stop`  in  1  level; aborts any scan, returns to IDLE.
- `mode`  in  1  0 = single pass, 1 = continuous.
- `ch_en`  in  4  channel enable mask; bit n enables mux input i[n].
- `y_in`  in  1  mux output `y`, fed back.
- `s0`  out  1  select MSB to mux; equals ch[1].
- `s1`  out  1  select LSB to mux; equals ch[0].
- `busy`  out  1  high in any state other than IDLE.
- `sample_valid`  out  1  one-cycle strobe; `sample_data`/`sample_ch` valid.
- `sample_data`  out  1  captured `y_in`.
- `sample_ch`  out  2  channel of the captured sample.
- `frame_valid`  out  1  one-cycle strobe at end of pass.
- `frame_data`  out  4  bit n = last sample of channel n in this pass; 0 for disabled channels.

## Operation
- Channel mapping:
  - ch = {s0, s1}.
  - ch 0 = 00, ch 1 = 01, ch 2 = 10, ch 3 = 11.
- States:
  - IDLE: `s0`=`s1`=0, `busy`=0.
  - SETTLE: select held, dwell counter runs.
  - SAMPLE: capture cycle.
- IDLE -> SETTLE on `start`=1, `stop`=0, `ch_en`!=0:
  - Latch `ch_en` into `en_q`.
  - ch = lowest set bit of `en_q`.
  - Clear counter and frame accumulator.
- Ignored starts:
  - `start` with `ch_en`=0 is ignored; stays IDLE.
  - `start` while busy is ignored.
- SETTLE -> SAMPLE when counter == DWELL-1; otherwise increment the counter.
- SAMPLE, at the leaving edge:
  - `sample_data`<=`y_in`, `sample_ch`<=ch, `sample_valid`<=1.
  - Accumulator bit ch<=`y_in`.
  - Next ch = next set bit of `en_q` above ch, cyclic 3->0.
- End of pass: next ch <= current ch, i.e. wrap or a single enabled channel.
  - `frame_valid`<=1; `frame_data`<=accumulator including this sample.
  - Bits of disabled channels are 0.
  - mode=0: go to IDLE.
  - mode=1: re-latch `en_q` from `ch_en`, restart from its lowest set bit, go to SETTLE.
  - mode=1 with `ch_en` now 0: go to IDLE.
- Not end of pass: go to SETTLE on next ch, counter cleared.
- `ch_en` changes mid-pass have no effect until the next pass.
- `stop`=1 in SETTLE or SAMPLE:
  - Next state is IDLE.
  - No `sample_valid` or `frame_valid` for the interrupted channel/pass.
  - `s0`/`s1` go to 0.
- `stop` has priority over `start` and over the SAMPLE capture in the same cycle.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE.
  - `s0`,`s1`,`busy`,`sample_valid`,`sample_data`,`frame_valid` = 0.
  - `sample_ch`=0, `frame_data`=0, counter=0.
- Reset is effective immediately (async) and overrides any state, including mid-pass.
- `start` sampled at edge E0:
  - `s0`/`s1`/`busy` valid after E0.
  - `y_in` captured at edge E(DWELL+1).
  - `sample_valid` high in the cycle after E(DWELL+1).
- Select is stable DWELL+1 cycles before capture.
- Per-channel period is DWELL+1 cycles, back-to-back with no idle gap.
- `frame_valid` is coincident with the `sample_valid` of the last channel of the pass.
- `sample_valid` and `frame_valid` are never high for more than one consecutive cycle per event.
- `stop` seen at edge E: IDLE and `busy`=0 after E.
- Single pass: `busy` falls at the same edge that raises the final `sample_valid`.

## Test plan
- DWELL=4, mode=0, `ch_en`=1111, mux inputs i=0101, one `start` pulse:
  - `{s0,s1}` = 00,01,10,11, each held 5 cycles.
  - `sample_data` = 1,0,1,0 with `sample_ch` = 0,1,2,3.
  - `frame_valid` with `frame_data`=0101 on the 4th sample; `busy` low.
- mode=1, `ch_en`=1010, i=1111:
  - Channel order 1,3,1,3.
  - `frame_valid` every 2nd sample, `frame_data`=1010.
  - Change `ch_en` to 0100 mid-pass: the current pass completes on ch 3, then only ch 2 is scanned, `frame_valid` every sample.
- `stop` asserted during SETTLE of ch 2:
  - `busy`=0 and `{s0,s1}`=00 the next cycle.
  - No `sample_valid` for ch 2, no `frame_valid`.
- Ignored starts:
  - `start` with `ch_en`=0000: `busy` stays 0.
  - `start` re-pulsed while busy: sequence unaffected.
  - `start` and `stop` together in IDLE: stays IDLE.
- DWELL=1, `ch_en`=0001, mode=1: `sample_valid` and `frame_valid` pulse every 2 cycles, `{s0,s1}` stuck at 00.
- `rst` asserted asynchronously mid-SETTLE of ch 1:
  - All outputs 0 before the next clock edge.
  - After release, a new `start` restarts from the lowest enabled channel.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks enabled mux channels, settles, samples y_in, emits per-sample and per-pass results.
module mux_scan_ctrl #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic [3:0] ch_en,
  input  logic       y_in,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       sample_valid,
  output logic       sample_data,
  output logic [1:0] sample_ch,
  output logic       frame_valid,
  output logic [3:0] frame_data
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] en_q, en_n, acc, acc_n, acc_w, fd_n;
  logic [1:0] ch, ch_n, nxt, sc_n;
  logic sv_n, sd_n, fv_n;
  function automatic logic [1:0] lowest(input logic [3:0] m);
    return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
  endfunction
  // nearest enabled channel above c, cyclic; returns c itself when it is the only one
  function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] c);
    logic [1:0] r;
    r = c;
    for (int k = 3; k >= 1; k--)
      if (m[2'(int'(c) + k)]) r = 2'(int'(c) + k);
    return r;
  endfunction
  assign s0 = ch[1];
  assign s1 = ch[0];
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    en_n    = en_q;
    acc_n   = acc;
    ch_n    = ch;
    sv_n    = 1'b0;
    sd_n    = sample_data;
    sc_n    = sample_ch;
    fv_n    = 1'b0;
    fd_n    = frame_data;
    nxt     = next_ch(en_q, ch);
    acc_w   = acc;
    acc_w[ch] = y_in;
    if (state == IDLE) begin
      if (start && !stop && ch_en != 4'd0) begin
        state_n = SETTLE;
        en_n    = ch_en;
        ch_n    = lowest(ch_en);
        cnt_n   = 8'd0;
        acc_n   = 4'd0;
      end
    end else if (stop) begin
      state_n = IDLE;
      ch_n    = 2'd0;
      cnt_n   = 8'd0;
    end else if (state == SETTLE) begin
      state_n = (cnt == 8'(DWELL - 1)) ? SAMPLE : SETTLE;
      cnt_n   = (cnt == 8'(DWELL - 1)) ? cnt : cnt + 8'd1;
    end else begin
      sv_n  = 1'b1;
      sd_n  = y_in;
      sc_n  = ch;
      acc_n = acc_w;
      cnt_n = 8'd0;
      if (nxt <= ch) begin
        fv_n  = 1'b1;
        fd_n  = acc_w;
        acc_n = 4'd0;
        if (mode && ch_en != 4'd0) begin
          state_n = SETTLE;
          en_n    = ch_en;
          ch_n    = lowest(ch_en);
        end else begin
          state_n = IDLE;
          ch_n    = 2'd0;
        end
      end else begin
        state_n = SETTLE;
        ch_n    = nxt;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      en_q         <= 4'd0;
      acc          <= 4'd0;
      ch           <= 2'd0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= 1'b0;
      sample_ch    <= 2'd0;
      frame_valid  <= 1'b0;
      frame_data   <= 4'd0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      en_q         <= en_n;
      acc          <= acc_n;
      ch           <= ch_n;
      busy         <= state_n != IDLE;
      sample_valid <= sv_n;
      sample_data  <= sd_n;
      sample_ch    <= sc_n;
      frame_valid  <= fv_n;
      frame_data   <= fd_n;
    end
  end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: random and directed stimulus against a pass/slot-level reference model.
module tb_mux_scan_ctrl;
  localparam int D = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [3:0] ch_en = 4'd0, mux_i = 4'd0;
  logic y_in, s0, s1, busy, sample_valid, sample_data, frame_valid;
  logic [1:0] sample_ch;
  logic [3:0] frame_data;
  logic start2 = 1'b0;
  logic [3:0] mux2 = 4'b0001;
  logic y2, s0_2, s1_2, busy2, sv2, sd2, fv2;
  logic [1:0] sc2;
  logic [3:0] fd2;
  int tests = 0, errs = 0;
  int sel_q[$], slog[$], flog[$];
  int m_q[$];
  int m_idx = 0, m_age = 0, m_ch = 0, m_sc = 0;
  logic m_busy = 0, m_sv = 0, m_sd = 0, m_fv = 0, m_y = 0;
  logic [3:0] m_acc = 0, m_fd = 0;

  assign y_in = mux_i[{s0, s1}];
  assign y2   = mux2[{s0_2, s1_2}];

  mux_scan_ctrl #(.DWELL(D)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .ch_en(ch_en), .y_in(y_in),
    .s0(s0), .s1(s1), .busy(busy), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ch(sample_ch), .frame_valid(frame_valid), .frame_data(frame_data));

  mux_scan_ctrl #(.DWELL(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(1'b0), .mode(1'b1), .ch_en(4'b0001), .y_in(y2),
    .s0(s0_2), .s1(s1_2), .busy(busy2), .sample_valid(sv2), .sample_data(sd2),
    .sample_ch(sc2), .frame_valid(fv2), .frame_data(fd2));

  initial forever #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic m_load(input logic [3:0] e);
    m_q.delete();
    for (int n = 0; n < 4; n++) if (e[n]) m_q.push_back(n);
    m_idx = 0;
    m_age = 0;
    m_acc = 4'd0;
  endtask

  // reference model: a pass is the ordered list of enabled channels, each slot lasts D+1 edges
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 0; m_q.delete(); m_idx = 0; m_age = 0; m_acc = 0;
      m_sv = 0; m_sd = 0; m_sc = 0; m_fv = 0; m_fd = 0;
    end else begin
      m_sv = 0;
      m_fv = 0;
      if (!m_busy) begin
        if (start && !stop && ch_en != 0) begin
          m_load(ch_en);
          m_busy = 1;
        end
      end else if (stop) m_busy = 0;
      else if (m_age == D) begin
        m_ch = m_q[m_idx];
        m_y = mux_i[m_ch];
        m_sv = 1; m_sd = m_y; m_sc = m_ch;
        m_acc[m_ch] = m_y;
        if (m_idx == m_q.size() - 1) begin
          m_fv = 1;
          m_fd = m_acc;
          if (mode && ch_en != 0) m_load(ch_en);
          else m_busy = 0;
        end else begin
          m_idx++;
          m_age = 0;
        end
      end else m_age++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("busy", busy, m_busy);
      chk("sel", {s0, s1}, m_busy ? m_q[m_idx] : 0);
      chk("sample_valid", sample_valid, m_sv);
      if (m_sv) begin
        chk("sample_data", sample_data, m_sd);
        chk("sample_ch", sample_ch, m_sc);
      end
      chk("frame_valid", frame_valid, m_fv);
      if (m_fv) chk("frame_data", frame_data, m_fd);
      if (busy) sel_q.push_back({s0, s1});
      if (sample_valid) slog.push_back(sample_ch * 2 + sample_data);
      if (frame_valid) flog.push_back(frame_data);
    end
  end

  task automatic clr();
    sel_q.delete(); slog.delete(); flog.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string nm);
    for (int i = 0; i < 500 && flog.size() < n; i++) @(negedge clk);
    chk(nm, flog.size() >= n, 1);
  endtask

  task automatic wait_sel(input int v, input string nm);
    for (int i = 0; i < 200 && {s0, s1} != v; i++) @(negedge clk);
    chk(nm, {s0, s1}, v);
  endtask

  task automatic chk_log(input string nm, input int got[$], input int exp[$]);
    chk({nm, "_len"}, got.size() >= exp.size(), 1);
    foreach (exp[j]) if (j < got.size()) chk(nm, got[j], exp[j]);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_s0", s0, 0); chk("rst_s1", s1, 0); chk("rst_busy", busy, 0);
    chk("rst_sv", sample_valid, 0); chk("rst_sd", sample_data, 0); chk("rst_sc", sample_ch, 0);
    chk("rst_fv", frame_valid, 0); chk("rst_fd", frame_data, 0); chk("rst_busy2", busy2, 0);
    rst = 1'b0;
    @(negedge clk);
    // single pass over all channels, i=0101
    clr(); ch_en = 4'b1111; mode = 0; mux_i = 4'b0101;
    pulse_start();
    wait_frames(1, "t1_frame");
    repeat (3) @(negedge clk);
    chk("t1_busy_low", busy, 0);
    chk("t1_sel_len", sel_q.size(), 20);
    foreach (sel_q[j]) chk("t1_sel_hold", sel_q[j], j / 5);
    chk_log("t1_samples", slog, '{1, 2, 5, 6});
    chk_log("t1_frames", flog, '{5});
    // continuous on 1010, then switch to 0100 mid-pass
    clr(); ch_en = 4'b1010; mode = 1; mux_i = 4'b1111;
    pulse_start();
    wait_frames(2, "t2_frame2");
    ch_en = 4'b0100;
    wait_frames(5, "t2_frame5");
    chk_log("t2_samples", slog, '{3, 7, 3, 7, 3, 7, 5, 5});
    chk_log("t2_frames", flog, '{10, 10, 10, 4, 4});
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t2_stop_busy", busy, 0);
    // stop during settle of ch 2
    @(negedge clk);
    clr(); ch_en = 4'b1111; mode = 0;
    pulse_start();
    wait_sel(2, "t3_reach_ch2");
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t3_busy", busy, 0);
    chk("t3_sel", {s0, s1}, 0);
    repeat (12) @(negedge clk);
    chk("t3_nsamples", slog.size(), 2);
    chk("t3_nframes", flog.size(), 0);
    // ignored starts
    ch_en = 4'b0000;
    pulse_start();
    repeat (2) @(negedge clk);
    chk("t4_empty_mask", busy, 0);
    ch_en = 4'b1111; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("t4_start_stop", busy, 0);
    clr(); mux_i = 4'b0110;
    pulse_start();
    repeat (6) @(negedge clk);
    pulse_start();
    wait_frames(1, "t4_frame");
    repeat (3) @(negedge clk);
    chk("t4_sel_len", sel_q.size(), 20);
    chk_log("t4_samples", slog, '{0, 3, 5, 6});
    chk_log("t4_frames", flog, '{6});
    // async reset mid-settle of ch 1
    mux_i = 4'b1111;
    pulse_start();
    wait_sel(1, "t5_reach_ch1");
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0); chk("t5_s0", s0, 0); chk("t5_s1", s1, 0);
    chk("t5_sv", sample_valid, 0); chk("t5_fv", frame_valid, 0);
    chk("t5_sc", sample_ch, 0); chk("t5_fd", frame_data, 0);
    @(negedge clk);
    rst = 1'b0;
    clr(); ch_en = 4'b0110;
    pulse_start();
    wait_frames(1, "t5_frame");
    chk_log("t5_samples", slog, '{3, 5});
    chk_log("t5_frames", flog, '{6});
    // DWELL=1 single channel continuous
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      chk("t6_sv", sv2, (k >= 2 && k % 2 == 0));
      chk("t6_fv", fv2, (k >= 2 && k % 2 == 0));
      chk("t6_sel", {s0_2, s1_2}, 0);
      chk("t6_busy", busy2, 1);
      if (k >= 2 && k % 2 == 0) begin
        chk("t6_sd", sd2, 1);
        chk("t6_fd", fd2, 1);
      end
    end
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = ($urandom % 6) == 0;
      stop  = ($urandom % 50) == 0;
      mode  = 1'($urandom);
      ch_en = 4'($urandom);
      mux_i = 4'($urandom);
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
